cmp_result_tally: RTL and testbench

Downstream consumer of the 6-bit signed/unsigned comparator. It samples the registered one-hot result (Greater, Equal, Smaller) over a window of WIN_LEN valid results. It counts each outcome and flags any result that is not exactly one-hot. The bench and sweep controller use it to get per-window statistics and a sticky integrity flag without logging every vector.

---
 rtl/cmp_result_tally_if.sv | 28 ++
 rtl/cmp_result_tally.sv | 87 ++++++++
 tb/tb_cmp_result_tally.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_result_tally_if.sv
// Result-tally bus: comparator result inputs plus window status and counts.
// The master modport drives results and Start; the slave modport is the tally block.
interface cmp_result_tally_if #(
  parameter int CNT_W = 12
);
  logic             Start;
  logic             Valid;
  logic             Greater;
  logic             Equal;
  logic             Smaller;
  logic             Busy;
  logic             Done;
  logic             Error;
  logic [CNT_W-1:0] GtCount;
  logic [CNT_W-1:0] EqCount;
  logic [CNT_W-1:0] LtCount;
  logic [CNT_W-1:0] ErrCount;

  modport master (
    output Start, Valid, Greater, Equal, Smaller,
    input  Busy, Done, Error, GtCount, EqCount, LtCount, ErrCount
  );

  modport slave (
    input  Start, Valid, Greater, Equal, Smaller,
    output Busy, Done, Error, GtCount, EqCount, LtCount, ErrCount
  );
endinterface

// File: rtl/cmp_result_tally.sv
// Per-window tally of one-hot comparator results (GT/EQ/LT) with a sticky
// flag and count for any result that is not exactly one-hot.
module cmp_result_tally #(
  parameter int CNT_W   = 12,
  parameter int WIN_LEN = 4095
) (
  input  logic               CLK,
  input  logic               RST_N,
  cmp_result_tally_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt [4];
  logic             r_error;
  logic             r_busy;
  logic             r_done;

  logic [2:0] w_code;
  logic [3:0] w_hit;

  assign w_code = {bus.Greater, bus.Equal, bus.Smaller};

  // w_hit[0]=LT (001), [1]=EQ (010), [2]=GT (100); [3] catches every other code
  for (genvar gi = 0; gi < 3; gi++) begin : g_hit
    assign w_hit[gi] = (w_code == 3'(1 << gi));
  end
  assign w_hit[3] = ~|w_hit[2:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_error <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RUN: begin
          if (bus.Start) begin
            // restart wins over a coincident Valid, which is dropped
            r_idx   <= '0;
            r_error <= 1'b0;
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
          end else if (bus.Valid) begin
            r_idx <= r_idx + 1'b1;
            for (int k = 0; k < 4; k++) begin
              if (w_hit[k]) r_cnt[k] <= r_cnt[k] + 1'b1;
            end
            if (w_hit[3]) r_error <= 1'b1;
            if (r_idx == LAST_IDX) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept Start; counts hold otherwise
          if (bus.Start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_error <= 1'b0;
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.Busy     = r_busy;
  assign bus.Done     = r_done;
  assign bus.Error    = r_error;
  assign bus.LtCount  = r_cnt[0];
  assign bus.EqCount  = r_cnt[1];
  assign bus.GtCount  = r_cnt[2];
  assign bus.ErrCount = r_cnt[3];
endmodule

// File: tb/tb_cmp_result_tally.sv
// Scoreboarded bench for cmp_result_tally: stimulus pushes expected window
// results, a monitor pops and compares them whenever a DUT pulses Done.
module tb_cmp_result_tally;
  localparam int CNT_W = 12;

  logic CLK;
  logic RST_N;

  cmp_result_tally_if #(.CNT_W(CNT_W)) bus4 ();
  cmp_result_tally_if #(.CNT_W(CNT_W)) bus3 ();
  cmp_result_tally_if #(.CNT_W(CNT_W)) busf ();

  cmp_result_tally #(.CNT_W(CNT_W), .WIN_LEN(4)) dut4 (.CLK(CLK), .RST_N(RST_N), .bus(bus4));
  cmp_result_tally #(.CNT_W(CNT_W), .WIN_LEN(3)) dut3 (.CLK(CLK), .RST_N(RST_N), .bus(bus3));
  cmp_result_tally #(.CNT_W(CNT_W))              dutf (.CLK(CLK), .RST_N(RST_N), .bus(busf));

  typedef struct {
    int gt;
    int eq;
    int lt;
    int err;
    int error;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t qf[$];

  int errors = 0;
  int checks = 0;
  int donef_cnt = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_window(input string name, input exp_t e, input int gt, input int eq,
                            input int lt, input int err, input int error);
    check({name, ".gt"}, gt, e.gt);
    check({name, ".eq"}, eq, e.eq);
    check({name, ".lt"}, lt, e.lt);
    check({name, ".err"}, err, e.err);
    check({name, ".error"}, error, e.error);
    $display("window %s: gt=%0d eq=%0d lt=%0d err=%0d error=%0d", name, gt, eq, lt, err, error);
  endtask

  // which: 4, 3 or 0 (full-window instance); code is {G,E,S}
  task automatic drive(input int which, input logic st, input logic v, input logic [2:0] code);
    bus4.Start = 1'b0; bus4.Valid = 1'b0; {bus4.Greater, bus4.Equal, bus4.Smaller} = 3'b000;
    bus3.Start = 1'b0; bus3.Valid = 1'b0; {bus3.Greater, bus3.Equal, bus3.Smaller} = 3'b000;
    busf.Start = 1'b0; busf.Valid = 1'b0; {busf.Greater, busf.Equal, busf.Smaller} = 3'b000;
    case (which)
      4: begin bus4.Start = st; bus4.Valid = v; {bus4.Greater, bus4.Equal, bus4.Smaller} = code; end
      3: begin bus3.Start = st; bus3.Valid = v; {bus3.Greater, bus3.Equal, bus3.Smaller} = code; end
      default: begin busf.Start = st; busf.Valid = v; {busf.Greater, busf.Equal, busf.Smaller} = code; end
    endcase
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4, 1'b0, 1'b0, 3'b000);
  endtask

  // Monitor: every Done pulse must match the oldest expected window of that instance
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus4.Done) begin
        if (q4.size() == 0) check("dut4.unexpected_done", 1, 0);
        else begin
          e = q4.pop_front();
          cmp_window("dut4", e, int'(bus4.GtCount), int'(bus4.EqCount), int'(bus4.LtCount),
                     int'(bus4.ErrCount), int'(bus4.Error));
        end
      end
      if (bus3.Done) begin
        if (q3.size() == 0) check("dut3.unexpected_done", 1, 0);
        else begin
          e = q3.pop_front();
          cmp_window("dut3", e, int'(bus3.GtCount), int'(bus3.EqCount), int'(bus3.LtCount),
                     int'(bus3.ErrCount), int'(bus3.Error));
        end
      end
      if (busf.Done) begin
        donef_cnt++;
        if (qf.size() == 0) check("dutf.unexpected_done", 1, 0);
        else begin
          e = qf.pop_front();
          cmp_window("dutf", e, int'(busf.GtCount), int'(busf.EqCount), int'(busf.LtCount),
                     int'(busf.ErrCount), int'(busf.Error));
        end
      end
    end
  end

  initial begin
    logic [12:0] v;
    logic [5:0]  a;
    logic [5:0]  b;
    int          sgt;
    int          seq;
    int          slt;

    RST_N = 1'b0;
    drive(4, 1'b0, 1'b0, 3'b000);
    drive(4, 1'b0, 1'b0, 3'b000);
    check("reset.busy", int'(bus4.Busy), 0);
    check("reset.done", int'(bus4.Done), 0);
    check("reset.error", int'(bus4.Error), 0);
    check("reset.gt", int'(bus4.GtCount), 0);
    #4 RST_N = 1'b1;
    idle(2);

    // Reset mid-window: counts vanish immediately, no Done afterwards
    drive(4, 1'b1, 1'b0, 3'b000);
    check("start.busy", int'(bus4.Busy), 1);
    for (int i = 0; i < 3; i++) drive(4, 1'b0, 1'b1, 3'b100);
    check("midwin.gt_before_rst", int'(bus4.GtCount), 3);
    #2 RST_N = 1'b0;
    #1;
    check("midwin.rst_gt", int'(bus4.GtCount), 0);
    check("midwin.rst_busy", int'(bus4.Busy), 0);
    check("midwin.rst_done", int'(bus4.Done), 0);
    #1 RST_N = 1'b1;
    $display("reset mid-window applied and released");
    idle(6);
    check("midwin.no_done_busy", int'(bus4.Busy), 0);

    // Basic window
    q4.push_back('{gt: 2, eq: 1, lt: 1, err: 0, error: 0});
    drive(4, 1'b1, 1'b0, 3'b000);
    drive(4, 1'b0, 1'b1, 3'b100);
    drive(4, 1'b0, 1'b1, 3'b010);
    drive(4, 1'b0, 1'b1, 3'b001);
    check("basic.done_before_last", int'(bus4.Done), 0);
    drive(4, 1'b0, 1'b1, 3'b100);
    check("basic.done", int'(bus4.Done), 1);
    check("basic.busy_at_done", int'(bus4.Busy), 0);
    idle(2);
    check("basic.done_cleared", int'(bus4.Done), 0);
    check("basic.gt_hold", int'(bus4.GtCount), 2);

    // Illegal codes; Error sticks through IDLE, clears on Start
    q4.push_back('{gt: 0, eq: 1, lt: 1, err: 2, error: 1});
    drive(4, 1'b1, 1'b0, 3'b000);
    drive(4, 1'b0, 1'b1, 3'b110);
    drive(4, 1'b0, 1'b1, 3'b000);
    drive(4, 1'b0, 1'b1, 3'b010);
    drive(4, 1'b0, 1'b1, 3'b001);
    check("illegal.done", int'(bus4.Done), 1);
    idle(3);
    check("illegal.error_idle", int'(bus4.Error), 1);
    drive(4, 1'b1, 1'b0, 3'b000);
    check("illegal.error_cleared", int'(bus4.Error), 0);
    check("illegal.errcnt_cleared", int'(bus4.ErrCount), 0);

    // Restart in RUN with a coincident Valid that must be dropped
    q4.push_back('{gt: 0, eq: 3, lt: 1, err: 0, error: 0});
    drive(4, 1'b0, 1'b1, 3'b100);
    drive(4, 1'b0, 1'b1, 3'b100);
    drive(4, 1'b1, 1'b1, 3'b010);
    check("restart.gt_cleared", int'(bus4.GtCount), 0);
    check("restart.eq_dropped", int'(bus4.EqCount), 0);
    check("restart.busy", int'(bus4.Busy), 1);
    drive(4, 1'b0, 1'b1, 3'b010);
    drive(4, 1'b0, 1'b1, 3'b010);
    drive(4, 1'b0, 1'b1, 3'b010);
    check("restart.no_early_done", int'(bus4.Done), 0);
    drive(4, 1'b0, 1'b1, 3'b001);
    check("restart.done", int'(bus4.Done), 1);
    idle(2);

    // Valid gaps and ignored IDLE Valid (WIN_LEN=3)
    drive(3, 1'b0, 1'b1, 3'b100);
    check("gaps.idle_valid_gt", int'(bus3.GtCount), 0);
    check("gaps.idle_busy", int'(bus3.Busy), 0);
    q3.push_back('{gt: 3, eq: 0, lt: 0, err: 0, error: 0});
    drive(3, 1'b1, 1'b0, 3'b000);
    drive(3, 1'b0, 1'b1, 3'b100);
    drive(3, 1'b0, 1'b0, 3'b100);
    drive(3, 1'b0, 1'b0, 3'b100);
    drive(3, 1'b0, 1'b1, 3'b100);
    drive(3, 1'b0, 1'b0, 3'b100);
    check("gaps.no_early_done", int'(bus3.Done), 0);
    check("gaps.busy_in_gap", int'(bus3.Busy), 1);
    drive(3, 1'b0, 1'b1, 3'b100);
    check("gaps.done", int'(bus3.Done), 1);
    idle(2);

    // Full sweep: first 4095 vectors of the {A,B,S} increment sweep
    sgt = 0; seq = 0; slt = 0;
    for (int i = 0; i < 4095; i++) begin
      v = 13'(i);
      a = v[12:7];
      b = v[6:1];
      if (v[0] ? ($signed(a) > $signed(b)) : (a > b)) sgt++;
      else if (a == b) seq++;
      else slt++;
    end
    qf.push_back('{gt: sgt, eq: seq, lt: slt, err: 0, error: 0});
    $display("sweep expected gt=%0d eq=%0d lt=%0d", sgt, seq, slt);
    drive(0, 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 4095; i++) begin
      v = 13'(i);
      a = v[12:7];
      b = v[6:1];
      if (v[0] ? ($signed(a) > $signed(b)) : (a > b)) drive(0, 1'b0, 1'b1, 3'b100);
      else if (a == b) drive(0, 1'b0, 1'b1, 3'b010);
      else drive(0, 1'b0, 1'b1, 3'b001);
    end
    check("sweep.done", int'(busf.Done), 1);
    idle(4);
    check("sweep.done_once", donef_cnt, 1);
    check("sweep.sum", int'(busf.GtCount) + int'(busf.EqCount) + int'(busf.LtCount)
                       + int'(busf.ErrCount), 4095);

    check("q4.pending", q4.size(), 0);
    check("q3.pending", q3.size(), 0);
    check("qf.pending", qf.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
